// File: rtl/block_pixel_renderer.sv
// rtl/block_pixel_renderer.sv - rasterises one clipped block per request into single-pixel writes
//
// Purpose:
//   Accepts one draw request at a time (valid/ready). It latches the block's
//   position, width and colour (or the background colour when erasing), clips
//   the block to the screen and emits one registered pixel write per clock in
//   row-major order. A one-cycle done pulse follows the last pixel.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   req_valid_i    draw request present
//   req_ready_o    renderer can accept a request (IDLE)
//   req_x_i        left column of block
//   req_y_i        top row of block
//   req_w_i        block width in pixels
//   req_colour_i   fill colour
//   req_erase_i    1 = fill with BG_COLOUR instead of req_colour_i
//   plot_o         pixel write strobe
//   out_x_o        pixel column
//   out_y_o        pixel row
//   out_colour_o   pixel colour
//   busy_o         request in progress (DRAW)
//   done_o         one-cycle pulse after the last pixel of a request

module block_pixel_renderer #(
  parameter int BLOCK_H   = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int COLOUR_W  = 3,
  parameter int BG_COLOUR = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [7:0]          req_x_i,
  input  logic [6:0]          req_y_i,
  input  logic [7:0]          req_w_i,
  input  logic [COLOUR_W-1:0] req_colour_i,
  input  logic                req_erase_i,
  output logic                plot_o,
  output logic [7:0]          out_x_o,
  output logic [6:0]          out_y_o,
  output logic [COLOUR_W-1:0] out_colour_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAW   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [8:0]          SCR_W = 9'(SCREEN_W);
  localparam logic [8:0]          SCR_H = 9'(SCREEN_H);
  localparam logic [8:0]          BLK_H = 9'(BLOCK_H);
  localparam logic [COLOUR_W-1:0] BG    = COLOUR_W'(BG_COLOUR);

  logic [1:0]          state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [7:0]          eff_w_q, eff_w_d;
  logic [3:0]          eff_h_q, eff_h_d;
  logic [7:0]          col_q, col_d;
  logic [3:0]          row_q, row_d;
  // Set once the final pixel has been registered; the following DRAW cycle
  // then retires the request so that done lands after the last plot cycle.
  logic                last_q, last_d;
  logic                plot_q, plot_d;
  logic [7:0]          out_x_q, out_x_d;
  logic [6:0]          out_y_q, out_y_d;
  logic [COLOUR_W-1:0] out_colour_q, out_colour_d;
  logic                done_q, done_d;

  // Clipped extent, 9-bit so that an off-screen origin yields 0 rather than
  // wrapping around.
  logic [8:0] avail_w, avail_h;
  logic [8:0] clip_w, clip_h;
  logic       req_empty;

  always_comb begin
    avail_w = ({1'b0, req_x_i} >= SCR_W) ? 9'd0 : (SCR_W - {1'b0, req_x_i});
    avail_h = ({2'b00, req_y_i} >= SCR_H) ? 9'd0 : (SCR_H - {2'b00, req_y_i});
    clip_w  = ({1'b0, req_w_i} < avail_w) ? {1'b0, req_w_i} : avail_w;
    clip_h  = (BLK_H < avail_h) ? BLK_H : avail_h;
    // Covers x off-screen, y off-screen and zero width alike.
    req_empty = (clip_w == 9'd0) || (clip_h == 9'd0);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    eff_w_d      = eff_w_q;
    eff_h_d      = eff_h_q;
    col_d        = col_q;
    row_d        = row_q;
    last_d       = last_q;
    plot_d       = 1'b0;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          x_d      = req_x_i;
          y_d      = req_y_i;
          colour_d = req_erase_i ? BG : req_colour_i;
          eff_w_d  = clip_w[7:0];
          eff_h_d  = clip_h[3:0];
          col_d    = 8'd0;
          row_d    = 4'd0;
          last_d   = 1'b0;
          if (req_empty) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end

      ST_DRAW: begin
        if (last_q) begin
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          plot_d       = 1'b1;
          out_x_d      = x_q + col_q;
          out_y_d      = y_q + {3'b000, row_q};
          out_colour_d = colour_q;
          if (col_q == eff_w_q - 8'd1) begin
            col_d = 8'd0;
            row_d = row_q + 4'd1;
            if (row_q == eff_h_q - 4'd1) begin
              last_d = 1'b1;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= '0;
      eff_w_q      <= 8'd0;
      eff_h_q      <= 4'd0;
      col_q        <= 8'd0;
      row_q        <= 4'd0;
      last_q       <= 1'b0;
      plot_q       <= 1'b0;
      out_x_q      <= 8'd0;
      out_y_q      <= 7'd0;
      out_colour_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      eff_w_q      <= eff_w_d;
      eff_h_q      <= eff_h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      plot_q       <= plot_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      done_q       <= done_d;
    end
  end

  // Handshake and status decode straight from the state flop.
  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_DRAW);
  assign plot_o       = plot_q;
  assign out_x_o      = out_x_q;
  assign out_y_o      = out_y_q;
  assign out_colour_o = out_colour_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_block_pixel_renderer.sv
// tb/tb_block_pixel_renderer.sv - directed self-checking bench for block_pixel_renderer

module tb_block_pixel_renderer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [2:0] req_colour;
  logic       req_erase;
  logic       plot;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  block_pixel_renderer #(
    .BLOCK_H(4), .SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3), .BG_COLOUR(0)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y), .req_w_i(req_w),
    .req_colour_i(req_colour), .req_erase_i(req_erase),
    .plot_o(plot), .out_x_o(out_x), .out_y_o(out_y), .out_colour_o(out_colour),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_x = 8'd0; req_y = 7'd0;
    req_w = 8'd0; req_colour = 3'd0; req_erase = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || out_x !== 8'd0 || out_y !== 7'd0 || out_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: plot=%0d x=%0d y=%0d c=%0d, expected all 0", plot, out_x, out_y, out_colour);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: busy=%0d done=%0d ready=%0d, expected 0 0 1", busy, done, req_ready);
    end
  endtask

  // Sends one request and checks the complete response timeline against the
  // hand-computed clipped extent (ew x eh) and expected colour ec.
  task automatic run_block(input string name, input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] w, input logic [2:0] c, input logic e,
                           input int ew, input int eh, input logic [2:0] ec);
    @(negedge clk);
    req_x = x; req_y = y; req_w = w; req_colour = c; req_erase = e; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: ready=%0d, expected 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (ew * eh == 0) begin
      checks++;
      if (plot !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_empty_done: plot=%0d done=%0d busy=%0d ready=%0d, expected 0 1 0 0",
                 name, plot, done, busy, req_ready);
      end
    end else begin
      checks++;
      if (plot !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_accept: plot=%0d busy=%0d ready=%0d, expected 0 1 0", name, plot, busy, req_ready);
      end
      for (int r = 0; r < eh; r++) begin
        for (int k = 0; k < ew; k++) begin
          @(negedge clk);
          checks++;
          if (plot !== 1'b1 || out_x !== 8'(int'(x) + k) || out_y !== 7'(int'(y) + r) || out_colour !== ec) begin
            errors++;
            $display("FAIL %s_pixel: plot=%0d (%0d,%0d) c=%0d, expected 1 (%0d,%0d) c=%0d",
                     name, plot, out_x, out_y, out_colour, int'(x) + k, int'(y) + r, ec);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (plot !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_done: plot=%0d done=%0d busy=%0d ready=%0d, expected 0 1 0 0",
                 name, plot, done, busy, req_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%0d ready=%0d plot=%0d, expected 0 1 0", name, done, req_ready, plot);
    end
  endtask

  task automatic test_basic();
    run_block("basic", 8'd10, 7'd20, 8'd3, 3'd5, 1'b0, 3, 4, 3'd5);
  endtask

  task automatic test_clip();
    run_block("clip", 8'd158, 7'd118, 8'd10, 3'd4, 1'b0, 2, 2, 3'd4);
  endtask

  task automatic test_degenerate();
    run_block("x_off", 8'd160, 7'd0, 8'd5, 3'd2, 1'b0, 0, 0, 3'd0);
    run_block("w_zero", 8'd0, 7'd0, 8'd0, 3'd2, 1'b0, 0, 0, 3'd0);
    run_block("y_off", 8'd5, 7'd120, 8'd5, 3'd2, 1'b0, 0, 0, 3'd0);
  endtask

  task automatic test_erase();
    run_block("erase", 8'd0, 7'd0, 8'd1, 3'd7, 1'b1, 1, 4, 3'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_x = 8'd50; req_y = 7'd60; req_w = 8'd2; req_colour = 3'd3; req_erase = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_accept: busy=%0d plot=%0d, expected 1 0", busy, plot);
    end
    req_x = 8'd99; req_y = 7'd99; req_w = 8'd9; req_colour = 3'd1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        checks++;
        if (plot !== 1'b1 || out_x !== 8'(50 + k) || out_y !== 7'(60 + r) || out_colour !== 3'd3) begin
          errors++;
          $display("FAIL b2b_pixel_a: plot=%0d (%0d,%0d) c=%0d, expected 1 (%0d,%0d) c=3",
                   plot, out_x, out_y, out_colour, 50 + k, 60 + r);
        end
        if (r == 1 && k == 1) begin
          req_x = 8'd70; req_y = 7'd30; req_w = 8'd1; req_colour = 3'd6;
        end
      end
    end
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || done !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_a: plot=%0d done=%0d ready=%0d, expected 0 1 0", plot, done, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: ready=%0d plot=%0d done=%0d, expected 1 0 0", req_ready, plot, done);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%0d plot=%0d, expected 1 0", busy, plot);
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++;
      if (plot !== 1'b1 || out_x !== 8'd70 || out_y !== 7'(30 + r) || out_colour !== 3'd6) begin
        errors++;
        $display("FAIL b2b_pixel_b: plot=%0d (%0d,%0d) c=%0d, expected 1 (70,%0d) c=6",
                 plot, out_x, out_y, out_colour, 30 + r);
      end
    end
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_b: plot=%0d done=%0d, expected 0 1", plot, done);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: ready=%0d done=%0d busy=%0d, expected 1 0 0", req_ready, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int plots;
    int dones;
    @(negedge clk);
    req_x = 8'd0; req_y = 7'd50; req_w = 8'd8; req_colour = 3'd2; req_erase = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (plot !== 1'b1 || out_x !== 8'(k) || out_y !== 7'd50 || out_colour !== 3'd2) begin
        errors++;
        $display("FAIL rst_mid_pixel: plot=%0d (%0d,%0d) c=%0d, expected 1 (%0d,50) c=2",
                 plot, out_x, out_y, out_colour, k);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: plot=%0d busy=%0d done=%0d, expected 0 0 0", plot, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || out_x !== 8'd0 || out_y !== 7'd0 || out_colour !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_release: ready=%0d x=%0d y=%0d c=%0d, expected 1 0 0 0",
               req_ready, out_x, out_y, out_colour);
    end
    plots = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (plot === 1'b1) plots++;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (plots != 0 || dones != 0) begin
      errors++;
      $display("FAIL rst_mid_residual: plots=%0d dones=%0d, expected 0 0", plots, dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_degenerate();
    test_erase();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/block_pixel_renderer.md
Name: block_pixel_renderer

Overview:
- Consumer side of the game logic's block-position outputs (x 8-bit, y 7-bit on the 160x120 grid).
- Accepts one "draw block" request at a time over a valid/ready handshake.
- Rasterises the block into a stream of single-pixel writes (x, y, colour, plot strobe), one pixel per clock, for the VGA adapter.
- Clips to the screen, supports erase (background colour) and flags completion with a one-cycle pulse.

Parameters:
BLOCK_H, 4, block height in rows (1..15)
SCREEN_W, 160, visible columns
SCREEN_H, 120, visible rows
COLOUR_W, 3, colour bus width
BG_COLOUR, 0, colour driven when erasing

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  draw request present
req_ready  output  1  renderer can accept a request
req_x  input  8  left column of block
req_y  input  7  top row of block
req_w  input  8  block width in pixels
req_colour  input  COLOUR_W  fill colour
req_erase  input  1  1 = fill with BG_COLOUR instead of req_colour
plot  output  1  pixel write strobe to VGA adapter
out_x  output  8  pixel column
out_y  output  7  pixel row
out_colour  output  COLOUR_W  pixel colour
busy  output  1  request in progress
done  output  1  one-cycle pulse after last pixel of a request

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high.
- Reset (async, any time, including mid-request):
  - State goes to IDLE; all counters are cleared; the latched request is discarded.
  - plot=0, out_x=0, out_y=0, out_colour=0, busy=0, done=0, req_ready=1 on release.
- FSM states:
  - IDLE: req_ready=1, busy=0.
    - On req_valid&&req_ready, latch x, y, colour (BG_COLOUR if req_erase) and compute the clipped extent:
      - eff_w = min(req_w, SCREEN_W-req_x)
      - eff_h = min(BLOCK_H, SCREEN_H-req_y)
      - Compute both in 9-bit arithmetic; a difference of 0 or less gives 0.
    - If req_x>=SCREEN_W, req_y>=SCREEN_H or req_w==0, go to FINISH (no pixels). Otherwise go to DRAW.
  - DRAW: req_ready=0, busy=1. Each cycle emits one registered pixel:
    - plot=1, out_x=x+col, out_y=y+row, out_colour=latched colour.
    - col increments 0..eff_w-1. On wrap, col returns to 0 and row increments (raster order, row-major).
    - After pixel (eff_w-1, eff_h-1) is emitted, go to FINISH.
  - FINISH: one cycle. plot=0, done=1, busy=0, req_ready=0. Then go to IDLE.
- Timing:
  - Request accepted at edge N; first plot=1 is visible after edge N+1.
  - Pixel count is exactly eff_w*eff_h, with no gaps between pixels.
  - done=1 in the cycle after the last plot cycle.
  - Earliest next acceptance is the cycle after done.
- Outputs are registered. out_x/out_y/out_colour hold their last values when plot=0.
- Request inputs are sampled only at acceptance. Changes while busy are ignored; a req_valid held high is not consumed until IDLE.
- Width rules:
  - req_w up to 255 is legal; clipping guarantees out_x<=SCREEN_W-1 and out_y<=SCREEN_H-1.
  - No coordinate wrap-around is ever emitted.
- Simultaneous events: reset overrides everything. No request is accepted in the FINISH cycle.

Test Plan:
- Reset, then request x=10, y=20, w=3, colour=5 → after acceptance, 12 consecutive plot cycles.
  - Pixels in order: (10,20)(11,20)(12,20)(10,21)…(12,23), all colour 5.
  - done pulses once in the next cycle; req_ready returns to 1 the cycle after.
- Request x=158, y=118, w=10 → eff_w=2, eff_h=2. Exactly 4 pixels: (158,118)(159,118)(158,119)(159,119), then done.
- Degenerate requests, one per run: x=160, y=0, w=5; then x=0, y=0, w=0 → zero plot cycles, done one cycle after acceptance.
- Erase: x=0, y=0, w=1, req_erase=1, req_colour=7 → 4 pixels (0,0)…(0,3), all out_colour=0.
- Back-to-back: req_valid held high with changing payload during DRAW → second request accepted only in IDLE, with the payload present at that cycle. No pixel overlap between the two requests.
- Assert reset during the 5th pixel of a w=8 request → plot, busy and done go to 0 immediately (asynchronously). After release, req_ready=1 and no residual pixels are emitted.
